irq_aggregator_csr: RTL and testbench

//  Collects NUM_IRQ kernel/board interrupt sources, synchronises them to clk, latches them per

---
 rtl/irq_aggregator_csr_if.sv | 35 +++
 rtl/irq_aggregator_csr.sv | 113 +++++++++++
 tb/tb_irq_aggregator_csr.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_aggregator_csr_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator CSR block.
// The host side uses the master modport; the aggregator uses the slave modport.
interface irq_aggregator_csr_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [2:0]            avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [DATA_WIDTH-1:0] avs_writedata;
  logic [DATA_WIDTH-1:0] avs_readdata;
  logic                  avs_readdatavalid;
  logic                  avs_waitrequest;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  avs_readdatavalid,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output avs_readdatavalid,
    output avs_waitrequest
  );

endinterface

// File: rtl/irq_aggregator_csr.sv
// Interrupt aggregator: synchronises NUM_IRQ sources, latches them per edge/level mode,
// masks them into one registered 'interrupt' level, and exposes CSRs over Avalon-MM.
module irq_aggregator_csr #(
  parameter int NUM_IRQ     = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_IRQ-1:0]   irq_src,
  irq_aggregator_csr_if.slave  avs,
  output logic                 interrupt
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR   = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_MASKED  = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;

  logic [NUM_IRQ-1:0]    sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]    sync_s;
  logic [NUM_IRQ-1:0]    prev_s;
  logic [NUM_IRQ-1:0]    pending;
  logic [NUM_IRQ-1:0]    pending_next;
  logic [NUM_IRQ-1:0]    mask;
  logic [NUM_IRQ-1:0]    mode;
  logic [NUM_IRQ-1:0]    wdata_irq;
  logic [NUM_IRQ-1:0]    clear_bits;
  logic [NUM_IRQ-1:0]    edge_bits;
  logic [DATA_WIDTH-1:0] read_mux;
  logic                  wr_mask;
  logic                  wr_clear;
  logic                  wr_mode;
  logic                  unused_wdata;

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign wdata_irq    = avs.avs_writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^avs.avs_writedata;

  assign wr_mask  = avs.avs_write && (avs.avs_address == ADDR_MASK);
  assign wr_clear = avs.avs_write && (avs.avs_address == ADDR_CLEAR);
  assign wr_mode  = avs.avs_write && (avs.avs_address == ADDR_MODE);

  assign avs.avs_waitrequest = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_s <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_s <= sync_s;
    end
  end

  // Edge bits: a fresh edge beats a same-cycle clear. Level bits simply follow the source.
  always_comb begin
    clear_bits   = wr_clear ? wdata_irq : '0;
    edge_bits    = sync_s & ~prev_s;
    pending_next = (mode & ((pending & ~clear_bits) | edge_bits)) | (~mode & sync_s);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending   <= '0;
      mask      <= '0;
      mode      <= '0;
      interrupt <= 1'b0;
    end else begin
      pending   <= pending_next;
      interrupt <= |(pending & mask);
      if (wr_mask) begin
        mask <= wdata_irq;
      end
      if (wr_mode) begin
        mode <= wdata_irq;
      end
    end
  end

  always_comb begin
    read_mux = '0;
    case (avs.avs_address)
      ADDR_PENDING: read_mux[NUM_IRQ-1:0] = pending;
      ADDR_MASK:    read_mux[NUM_IRQ-1:0] = mask;
      ADDR_MODE:    read_mux[NUM_IRQ-1:0] = mode;
      ADDR_MASKED:  read_mux[NUM_IRQ-1:0] = pending & mask;
      ADDR_RAW:     read_mux[NUM_IRQ-1:0] = sync_s;
      default:      read_mux = '0;
    endcase
  end

  // Reads sample current register state, so a same-cycle write is seen only by later reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      avs.avs_readdatavalid <= avs.avs_read;
      if (avs.avs_read) begin
        avs.avs_readdata <= read_mux;
      end
    end
  end

endmodule

// File: tb/tb_irq_aggregator_csr.sv
// Directed bench for irq_aggregator_csr: reads are scoreboarded through a queue popped by a
// monitor on readdatavalid; interrupt and reset values are compared directly.
module tb_irq_aggregator_csr;

  localparam int NUM_IRQ     = 8;
  localparam int DATA_WIDTH  = 32;
  localparam int SYNC_STAGES = 2;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [NUM_IRQ-1:0] irq_src = '0;
  logic               interrupt;

  irq_aggregator_csr_if #(.DATA_WIDTH(DATA_WIDTH)) avs ();

  irq_aggregator_csr #(
    .NUM_IRQ    (NUM_IRQ),
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .irq_src  (irq_src),
    .avs      (avs),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
    logic [2:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus cycle: drive, let one clock edge sample it, return just after that edge.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_data);
    avs.avs_read      = rd;
    avs.avs_write     = wr;
    avs.avs_address   = addr;
    avs.avs_writedata = wdata;
    if (rd) exp_q.push_back('{exp_data, cyc + 1, addr});
    @(posedge clk);
    #1;
    avs.avs_read  = 1'b0;
    avs.avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
    apply_stimulus(1'b0, 1'b1, addr, data, 32'h0);
  endtask

  task automatic read_reg(input logic [2:0] addr, input logic [31:0] expected);
    apply_stimulus(1'b1, 1'b0, addr, 32'h0, expected);
  endtask

  always @(negedge clk) begin
    if (avs.avs_readdatavalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_readdatavalid: got valid at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (avs.avs_readdata !== e.data || cyc != e.due) begin
          failures++;
          $display("[TB] FAIL read_addr%0d: readdata=0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                   e.addr, avs.avs_readdata, cyc, e.data, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missing_readdatavalid_addr%0d: no valid at cycle %0d, required 0x%0h",
               e.addr, cyc, e.data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] csr_exp [8];

    avs.avs_read      = 1'b0;
    avs.avs_write     = 1'b0;
    avs.avs_address   = 3'd0;
    avs.avs_writedata = 32'h0;

    #12;
    check_output("reset_interrupt", {31'h0, interrupt}, 32'h0);
    check_output("reset_readdatavalid", {31'h0, avs.avs_readdatavalid}, 32'h0);
    check_output("reset_readdata", avs.avs_readdata, 32'h0);
    check_output("waitrequest", {31'h0, avs.avs_waitrequest}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;

    read_reg(3'd0, 32'h0);
    read_reg(3'd1, 32'h0);
    read_reg(3'd3, 32'h0);

    // Masking in level mode
    irq_src = 8'h30;
    idle(3);
    read_reg(3'd0, 32'h30);
    check_output("mask0_interrupt", {31'h0, interrupt}, 32'h0);
    read_reg(3'd4, 32'h0);
    write_reg(3'd1, 32'h10);
    check_output("mask_write_same_edge", {31'h0, interrupt}, 32'h0);
    idle(1);
    check_output("mask_write_next_edge", {31'h0, interrupt}, 32'h1);
    read_reg(3'd4, 32'h10);
    write_reg(3'd2, 32'h30);
    read_reg(3'd0, 32'h30);

    // Back-to-back CSR sweep, width/unused-address behaviour, read+write collision
    csr_exp = '{32'h30, 32'h10, 32'h0, 32'h0, 32'h10, 32'h30, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) read_reg(3'(a), csr_exp[a]);
    write_reg(3'd1, 32'hFFFF_FF0F);
    read_reg(3'd1, 32'h0F);
    apply_stimulus(1'b1, 1'b1, 3'd1, 32'hA5, 32'h0F);
    read_reg(3'd1, 32'hA5);
    write_reg(3'd1, 32'h0);
    write_reg(3'd0, 32'hFF);
    write_reg(3'd5, 32'hFF);
    write_reg(3'd6, 32'hFF);
    read_reg(3'd0, 32'h30);
    read_reg(3'd5, 32'h30);
    read_reg(3'd6, 32'h0);

    // Edge latch on bit 0 with a single-cycle pulse, then W1C clear
    irq_src = 8'h00;
    idle(3);
    write_reg(3'd3, 32'h01);
    write_reg(3'd1, 32'h01);
    irq_src = 8'h01;
    idle(1);
    irq_src = 8'h00;
    idle(2);
    check_output("edge_latency_3", {31'h0, interrupt}, 32'h0);
    idle(1);
    check_output("edge_latency_4", {31'h0, interrupt}, 32'h1);
    idle(3);
    check_output("edge_hold", {31'h0, interrupt}, 32'h1);
    read_reg(3'd0, 32'h01);
    write_reg(3'd2, 32'h01);
    check_output("clear_latency_1", {31'h0, interrupt}, 32'h1);
    idle(1);
    check_output("clear_latency_2", {31'h0, interrupt}, 32'h0);

    // Edge on bit 2 lands in the same cycle as its clear
    write_reg(3'd3, 32'h05);
    irq_src = 8'h04;
    idle(2);
    write_reg(3'd2, 32'h04);
    read_reg(3'd0, 32'h04);
    write_reg(3'd2, 32'h04);
    read_reg(3'd0, 32'h00);
    irq_src = 8'h00;
    idle(3);

    // Level->edge switch on bit 3 keeps pending without a spurious edge
    irq_src = 8'h08;
    idle(3);
    read_reg(3'd0, 32'h08);
    write_reg(3'd3, 32'h0D);
    read_reg(3'd0, 32'h08);
    write_reg(3'd2, 32'h08);
    read_reg(3'd0, 32'h00);
    idle(4);
    read_reg(3'd0, 32'h00);
    irq_src = 8'h00;
    idle(3);
    irq_src = 8'h08;
    idle(3);
    read_reg(3'd0, 32'h08);
    irq_src = 8'h00;
    idle(2);
    write_reg(3'd3, 32'h00);
    read_reg(3'd0, 32'h08);
    read_reg(3'd0, 32'h00);

    // Asynchronous reset during activity, then level resync
    write_reg(3'd1, 32'hFF);
    irq_src = 8'hFF;
    idle(4);
    check_output("pre_reset_interrupt", {31'h0, interrupt}, 32'h1);
    read_reg(3'd0, 32'hFF);
    idle(1);
    #2 resetn = 1'b0;
    #1;
    check_output("async_reset_interrupt", {31'h0, interrupt}, 32'h0);
    check_output("async_reset_readdata", avs.avs_readdata, 32'h0);
    check_output("async_reset_readdatavalid", {31'h0, avs.avs_readdatavalid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    idle(1);
    read_reg(3'd0, 32'h00);
    read_reg(3'd0, 32'hFF);
    read_reg(3'd1, 32'h00);
    read_reg(3'd3, 32'h00);
    check_output("post_reset_interrupt", {31'h0, interrupt}, 32'h0);

    idle(2);
    check_output("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
